adc_spi_sampler: RTL and testbench
==================================

# adc_spi_sampler

- Upstream front end for the `fft` stage on the TinyFPGA BX.
- Paces ADC conversions at a fixed sample rate and drives the serial ADC (12-bit, MCP3201-style: CS, SCLK, data-out) as SPI master.
- Deserialises each conversion and presents it to the FFT input with a valid/ready handshake.
- Tags each sample with its position in the FFT frame.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period. Minimum 3; 4 gives 2 MHz SCLK at 16 MHz.
- `SAMPLE_BITS`, 12: data bits per conversion, MSB first.
- `LEAD_BITS`, 3: leading SCLK rising edges whose captured bits are discarded (sample/null bits).
- `SAMPLE_PERIOD`, 400: `clk` cycles between conversion starts (40 kHz). Must be ≥ 1 + 2·CLK_DIV·(LEAD_BITS+SAMPLE_BITS) + CLK_DIV.
- `FRAME_LEN`, 16: samples per FFT frame. Power of two.

Ports:
- `clk` in 1: 16 MHz system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: allow new conversions to start.
- `adc_miso` in 1: ADC serial data (PIN_9). Asynchronous; passes through a 2-flop synchroniser internally.
- `adc_sclk` out 1: SPI clock to ADC (PIN_2).
- `adc_cs_n` out 1: ADC chip select, active low (PIN_7).
- `data_out` out SAMPLE_BITS: sample to the FFT.
- `data_valid` out 1: `data_out` holds an untransferred sample.
- `data_ready` in 1: FFT accepts the sample. A transfer occurs on any cycle where `data_valid` and `data_ready` are both 1.
- `sample_index` out $clog2(FRAME_LEN): frame position of `data_out`.
- `frame_last` out 1: asserted when `sample_index` = FRAME_LEN-1.
- `overrun` out 1: sticky error flag.

## Operation
- **Rate timer**
  - Counts 0..SAMPLE_PERIOD-1 while `enable`=1; held at 0 while `enable`=0.
  - Terminal count produces a start tick.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD.
  - IDLE: `adc_cs_n`=1, `adc_sclk`=0. A start tick moves to SETUP.
  - SETUP: `adc_cs_n`=0 for CLK_DIV cycles, `adc_sclk`=0, then SHIFT.
  - SHIFT: `adc_sclk` toggles every CLK_DIV cycles, starting high, for N = LEAD_BITS+SAMPLE_BITS full periods.
    - The synchronised `adc_miso` is captured on each `clk` edge where `adc_sclk` goes 0→1.
    - The first LEAD_BITS captures are dropped; the remaining SAMPLE_BITS shift in MSB first.
    - After the last high phase, `adc_sclk`=0 and `adc_cs_n`=1 together, and the state moves to HOLD.
  - HOLD: `adc_cs_n`=1 for CLK_DIV cycles (minimum CS-high time), then IDLE.
- **Output register**, loaded on entry to HOLD:
  - If `data_valid`=0: load `data_out` and set `data_valid`=1.
  - If `data_valid`=1 (previous sample untransferred): keep the old sample, discard the new one, set `overrun`.
- **Missed start:** a start tick arriving outside IDLE is dropped and sets `overrun`.
- **Transfer:**
  - Clears `data_valid` the next cycle unless a new sample loads in the same cycle; the load wins.
  - Increments `sample_index` modulo FRAME_LEN.
- **Deasserting `enable`:** an in-progress conversion always completes; only new starts are suppressed.
- **Reset values:** `adc_cs_n`=1, `adc_sclk`=0, `data_out`=0, `data_valid`=0, `sample_index`=0, `frame_last`=0, `overrun`=0, timer=0, FSM=IDLE.
  - Reset mid-conversion aborts it: the partial word is discarded and no `data_valid` is produced.
- **Clearing `overrun`:** only `rst` clears it.

## Timing
- Start tick at cycle t. Let N = LEAD_BITS+SAMPLE_BITS.
- `adc_cs_n` falls at t+1.
- SCLK rising edge k (k = 0..N-1) at t+1+CLK_DIV+2·CLK_DIV·k.
- Last falling edge, `adc_cs_n` rise and `data_valid` rise all at t+1+2·CLK_DIV·N. Defaults: t+121.
- IDLE re-entered at t+1+2·CLK_DIV·N+CLK_DIV (t+125).
- `data_out` and `sample_index` are stable while `data_valid`=1 and `data_ready`=0.

## Configuration
- `ADC_SAMPLER_SIGNED_EN`
  - Defined: the MSB of each sample is inverted on load, converting offset binary to two's complement centred on 0 (0x800→0x000, 0xFFF→0x7FF, 0x000→0x800).
  - Undefined: raw unsigned ADC code.

## Test plan
- Assert `rst` mid-run → next cycle `adc_cs_n`=1, `adc_sclk`=0, `data_valid`=0, `overrun`=0, `sample_index`=0.
- ADC model returns 0xA5C after 3 lead bits, `data_ready`=1 → exactly 15 SCLK rising edges, `adc_cs_n` low for 120 cycles, `data_valid` pulses at t+121.
  - `data_out`=0xA5C with `ADC_SAMPLER_SIGNED_EN` undefined; 0x25C with it defined.
- Ramp 0..16 over 17 conversions, `data_ready`=1 → `sample_index` 0..15, `frame_last` only on value 15, 17th sample at index 0.
- `data_ready`=0 for two conversions (values 0x111 then 0x222) → `data_out` stays 0x111, `overrun`=1; raising `data_ready` transfers 0x111.
- Drop `enable` at the 5th SCLK edge → conversion completes with `data_valid`; no further `adc_cs_n` falls for 2000 cycles.
- Assert `rst` at the 8th SCLK rising edge → `adc_cs_n`=1 next cycle, no `data_valid`; after release and re-enable, the next conversion is correct.

Source files
------------

// File: rtl/adc_spi_sampler_if.sv
// Sample stream from adc_spi_sampler to the FFT input stage.
// Transfer happens on any cycle with data_valid and data_ready both high.
interface adc_spi_sampler_if #(
    parameter int SAMPLE_BITS = 12,
    parameter int FRAME_LEN   = 16
);
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic [SAMPLE_BITS-1:0] data_out;
    logic                   data_valid;
    logic                   data_ready;
    logic [IDX_W-1:0]       sample_index;
    logic                   frame_last;

    modport master (
        output data_out,
        output data_valid,
        output sample_index,
        output frame_last,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  sample_index,
        input  frame_last,
        output data_ready
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Paced SPI master for an MCP3201-style ADC feeding the FFT sample stream.
// Optional ADC_SAMPLER_SIGNED_EN: invert sample MSB (offset binary -> two's complement).
//
// state | meaning
// IDLE  | CS high, SCLK low, waiting for a rate-timer start tick
// SETUP | CS low for CLK_DIV cycles before the first SCLK rise
// SHIFT | SCLK toggling, MISO captured on every rising edge
// HOLD  | CS high for CLK_DIV cycles (minimum CS-high time)
module adc_spi_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_BITS   = 12,
    parameter int LEAD_BITS     = 3,
    parameter int SAMPLE_PERIOD = 400,
    parameter int FRAME_LEN     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic              overrun,
    adc_spi_sampler_if.master fft
);
    localparam int N_BITS = LEAD_BITS + SAMPLE_BITS;
    localparam int TMR_W  = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(N_BITS);
    localparam int IDX_W  = $clog2(FRAME_LEN);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   miso_meta_q, miso_meta_d;
    logic                   miso_sync_q, miso_sync_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   overrun_q, overrun_d;

    logic                   start_tick;
    logic                   capture;
    logic                   load;
    logic                   xfer;
    logic [SAMPLE_BITS-1:0] sample_word;

`ifdef ADC_SAMPLER_SIGNED_EN
    assign sample_word = {~shift_q[SAMPLE_BITS-1], shift_q[SAMPLE_BITS-2:0]};
`else
    assign sample_word = shift_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        index_d     = index_q;
        overrun_d   = overrun_q;
        miso_meta_d = adc_miso;
        miso_sync_d = miso_meta_q;
        capture     = 1'b0;
        load        = 1'b0;

        start_tick = enable && (timer_q == TMR_LAST);
        if (!enable || start_tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // A tick that lands mid-conversion is lost rather than queued.
        if (start_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_tick) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = DIV_LAST;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LAST;
                    bit_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = DIV_LAST;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                            cs_n_d  = 1'b1;
                            load    = 1'b1;
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + 1'b1;
                        capture = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lead bits simply fall off the top of the shift register.
        if (capture) begin
            shift_d = {shift_q[SAMPLE_BITS-2:0], miso_sync_q};
        end

        xfer = valid_q && fft.data_ready;
        if (xfer) begin
            valid_d = 1'b0;
            index_d = index_q + 1'b1;
        end
        if (load) begin
            if (!valid_q || xfer) begin
                data_d  = sample_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            index_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            miso_meta_q <= miso_meta_d;
            miso_sync_q <= miso_sync_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            overrun_q   <= overrun_d;
        end
    end

    assign adc_sclk         = sclk_q;
    assign adc_cs_n         = cs_n_q;
    assign overrun          = overrun_q;
    assign fft.data_out     = data_q;
    assign fft.data_valid   = valid_q;
    assign fft.sample_index = index_q;
    assign fft.frame_last   = (index_q == IDX_LAST);
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: ADC serial model, edge monitor, hand-computed expectations.
// Honours ADC_SAMPLER_SIGNED_EN when computing expected sample codes.
module tb_adc_spi_sampler;
    localparam int CLK_DIV = 4;
    localparam int SB      = 12;
    localparam int LB      = 3;
    localparam int PERIOD  = 400;
    localparam int FL      = 16;
    localparam int NB      = LB + SB;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic adc_miso;
    logic adc_sclk;
    logic adc_cs_n;
    logic overrun;

    adc_spi_sampler_if #(.SAMPLE_BITS(SB), .FRAME_LEN(FL)) fft_if ();

    adc_spi_sampler #(
        .CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB), .LEAD_BITS(LB),
        .SAMPLE_PERIOD(PERIOD), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_miso(adc_miso),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .overrun(overrun),
        .fft(fft_if)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_code(input logic [11:0] w);
`ifdef ADC_SAMPLER_SIGNED_EN
        return w ^ 12'h800;
`else
        return w;
`endif
    endfunction

    // ADC model: first bit presented at CS fall, next bit after each SCLK rise.
    logic [NB-1:0] adc_seq = '0;
    int adc_pos = 0;
    initial begin
        adc_miso = 1'b0;
        forever begin
            @(negedge adc_cs_n or posedge adc_sclk);
            if (adc_sclk === 1'b1) begin
                adc_pos++;
                if (adc_pos < NB) adc_miso = adc_seq[NB-1-adc_pos];
            end else begin
                adc_pos  = 0;
                adc_miso = adc_seq[NB-1];
            end
        end
    end

    // Edge monitor sampled on the falling clock edge.
    int cyc = 0, cs_falls = 0, cs_rises = 0, sclk_rises = 0, valid_rises = 0, xfer_cnt = 0;
    int last_cs_fall = 0, last_cs_rise = 0, first_rise = 0, last_valid_rise = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0, rise_seen = 1'b0;
    logic [11:0] xfer_data = '0;
    logic [3:0]  xfer_idx  = '0;
    logic        xfer_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            cs_falls++;
            last_cs_fall = cyc;
            rise_seen    = 1'b0;
        end
        if (prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
            cs_rises++;
            last_cs_rise = cyc;
        end
        if (prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
            sclk_rises++;
            if (!rise_seen) begin
                first_rise = cyc;
                rise_seen  = 1'b1;
            end
        end
        if (prev_valid === 1'b0 && fft_if.data_valid === 1'b1) begin
            valid_rises++;
            last_valid_rise = cyc;
        end
        if (fft_if.data_valid === 1'b1 && fft_if.data_ready === 1'b1) begin
            xfer_cnt++;
            xfer_data = fft_if.data_out;
            xfer_idx  = fft_if.sample_index;
            xfer_last = fft_if.frame_last;
        end
        prev_cs    = adc_cs_n;
        prev_sclk  = adc_sclk;
        prev_valid = fft_if.data_valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_xfer(input string tag, input int budget);
        int base;
        base = xfer_cnt;
        for (int i = 0; i < budget; i++) begin
            if (xfer_cnt > base) break;
            step();
        end
        check(tag, 32'(xfer_cnt), 32'(base + 1));
    endtask

    task automatic wait_rises(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sclk_rises >= target) break;
            step();
        end
        check(tag, 32'(sclk_rises), 32'(target));
    endtask

    int base_rises, base_vr, base_cs, prev_fall;

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        fft_if.data_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_data", 32'(fft_if.data_out), 32'd0);
        check("rst_valid", 32'(fft_if.data_valid), 32'd0);
        check("rst_index", 32'(fft_if.sample_index), 32'd0);
        check("rst_last", 32'(fft_if.frame_last), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Single conversion of 0xA5C with timing
        rst               = 1'b0;
        adc_seq           = {3'b101, 12'hA5C};
        fft_if.data_ready = 1'b1;
        base_rises        = sclk_rises;
        enable            = 1'b1;
        wait_xfer("a5c_xfer", 1000);
        check("a5c_data", 32'(xfer_data), 32'(exp_code(12'hA5C)));
        check("a5c_index", 32'(xfer_idx), 32'd0);
        check("a5c_sclk_rises", 32'(sclk_rises - base_rises), 32'(NB));
        check("a5c_cs_low", 32'(last_cs_rise - last_cs_fall), 32'd120);
        check("a5c_valid_time", 32'(last_valid_rise - last_cs_fall), 32'd120);
        check("a5c_first_sclk", 32'(first_rise - last_cs_fall), 32'(CLK_DIV));
        step();
        check("a5c_valid_drop", 32'(fft_if.data_valid), 32'd0);

        // Ramp 0..16: frame index wrap and frame_last
        do_reset();
        adc_seq = {3'b101, 12'h000};
        enable  = 1'b1;
        prev_fall = 0;
        for (int i = 0; i <= 16; i++) begin
            base_rises = sclk_rises;
            wait_xfer("ramp_xfer", 1000);
            check("ramp_data", 32'(xfer_data), 32'(exp_code(12'(i))));
            check("ramp_index", 32'(xfer_idx), 32'(i % FL));
            check("ramp_last", 32'(xfer_last), (i == 15) ? 32'd1 : 32'd0);
            check("ramp_rises", 32'(sclk_rises - base_rises), 32'(NB));
            if (i > 0) check("ramp_period", 32'(last_cs_fall - prev_fall), 32'(PERIOD));
            prev_fall = last_cs_fall;
            adc_seq = {3'b101, 12'(i + 1)};
        end
        check("ramp_overrun", 32'(overrun), 32'd0);

        // Backpressure: second sample discarded, overrun set
        do_reset();
        fft_if.data_ready = 1'b0;
        adc_seq           = {3'b101, 12'h111};
        base_vr           = valid_rises;
        enable            = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (valid_rises > base_vr) break;
            step();
        end
        check("ovr_first_valid", 32'(valid_rises), 32'(base_vr + 1));
        check("ovr_first_data", 32'(fft_if.data_out), 32'(exp_code(12'h111)));
        check("ovr_first_flag", 32'(overrun), 32'd0);
        adc_seq = {3'b101, 12'h222};
        base_cs = cs_rises;
        for (int i = 0; i < 1000; i++) begin
            if (cs_rises > base_cs) break;
            step();
        end
        check("ovr_second_done", 32'(cs_rises), 32'(base_cs + 1));
        step();
        step();
        check("ovr_data_kept", 32'(fft_if.data_out), 32'(exp_code(12'h111)));
        check("ovr_valid_held", 32'(fft_if.data_valid), 32'd1);
        check("ovr_index_held", 32'(fft_if.sample_index), 32'd0);
        check("ovr_flag", 32'(overrun), 32'd1);
        fft_if.data_ready = 1'b1;
        step();
        check("ovr_xfer_valid", 32'(fft_if.data_valid), 32'd0);
        check("ovr_xfer_index", 32'(fft_if.sample_index), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-run clears everything
        rst = 1'b1;
        step();
        check("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("mid_rst_sclk", 32'(adc_sclk), 32'd0);
        check("mid_rst_valid", 32'(fft_if.data_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_index", 32'(fft_if.sample_index), 32'd0);

        // Drop enable at the 5th SCLK edge: conversion still completes
        do_reset();
        fft_if.data_ready = 1'b1;
        adc_seq           = {3'b101, 12'h3C7};
        base_rises        = sclk_rises;
        enable            = 1'b1;
        wait_rises("en_5th_edge", base_rises + 5, 1000);
        enable = 1'b0;
        wait_xfer("en_xfer", 500);
        check("en_data", 32'(xfer_data), 32'(exp_code(12'h3C7)));
        check("en_rises", 32'(sclk_rises - base_rises), 32'(NB));
        base_cs = cs_falls;
        repeat (2000) step();
        check("en_no_restart", 32'(cs_falls), 32'(base_cs));

        // Reset at the 8th SCLK edge aborts the conversion
        do_reset();
        adc_seq    = {3'b101, 12'hBEE};
        base_rises = sclk_rises;
        enable     = 1'b1;
        wait_rises("abort_8th_edge", base_rises + 8, 1000);
        base_vr = valid_rises;
        rst     = 1'b1;
        enable  = 1'b0;
        step();
        check("abort_cs_n", 32'(adc_cs_n), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd0);
        check("abort_valid", 32'(fft_if.data_valid), 32'd0);
        rst = 1'b0;
        repeat (200) step();
        check("abort_no_valid", 32'(valid_rises), 32'(base_vr));
        adc_seq    = {3'b101, 12'h5E1};
        base_rises = sclk_rises;
        enable     = 1'b1;
        wait_xfer("abort_next_xfer", 1000);
        check("abort_next_data", 32'(xfer_data), 32'(exp_code(12'h5E1)));
        check("abort_next_index", 32'(xfer_idx), 32'd0);
        check("abort_next_rises", 32'(sclk_rises - base_rises), 32'(NB));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
